// File: rtl/rr_mux_arb.sv
// N-channel registered mux with valid/ready on every input and on the output.
// Channel choice is round-robin over requesters or fixed by sel_in.
module rr_mux_arb #(
  parameter int NUM_CH = 8,
  parameter int DATA_W = 8,
  localparam int CH_W = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  input  logic                     mode_fixed,
  input  logic [CH_W-1:0]          sel_in,
  output logic [DATA_W-1:0]        out_data,
  output logic [CH_W-1:0]          out_sel,
  output logic                     out_valid,
  input  logic                     out_ready
);

  // Handshake: a word moves on any edge where valid && ready are both high;
  // in_ready never depends on the granted channel's own data.
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t            state;
  logic [CH_W-1:0]   ptr;
  logic [CH_W-1:0]   gnt_idx;
  logic              gnt_vld;
  logic [DATA_W-1:0] gnt_data;
  logic              load;
  logic              take;
  int                idx;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    if (mode_fixed) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (sel_in == CH_W'(i) && in_valid[i]) begin
          gnt_vld = 1'b1;
          gnt_idx = CH_W'(i);
        end
      end
    end else begin
      // Walk from farthest to nearest offset so the channel right after ptr wins.
      for (int k = NUM_CH; k >= 1; k--) begin
        idx = int'(ptr) + k;
        if (idx >= NUM_CH) idx = idx - NUM_CH;
        if (in_valid[CH_W'(idx)]) begin
          gnt_vld = 1'b1;
          gnt_idx = CH_W'(idx);
        end
      end
    end
  end

  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt_idx == CH_W'(i)) gnt_data = in_data[i*DATA_W +: DATA_W];
    end
  end

  assign load      = (state == EMPTY) || out_ready;
  assign take      = load && gnt_vld && !rst;
  assign out_valid = (state == FULL);

  always_comb begin
    in_ready = '0;
    if (take) in_ready[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= EMPTY;
      out_data <= '0;
      out_sel  <= '0;
      ptr      <= CH_W'(NUM_CH - 1);
    end else if (take) begin
      state    <= FULL;
      out_data <= gnt_data;
      out_sel  <= gnt_idx;
      if (!mode_fixed) ptr <= gnt_idx;
    end else if (state == FULL && out_ready) begin
      state <= EMPTY;
    end
  end

endmodule

// File: tb/tb_rr_mux_arb.sv
// Bench for rr_mux_arb: 8-channel instance for the main scenarios and a
// 6-channel instance for out-of-range select and non-power-of-two wrap.
module tb_rr_mux_arb;
  localparam int N  = 8;
  localparam int N6 = 6;
  localparam int DW = 8;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_valid, in_ready;
  logic            mode_fixed, out_ready, out_valid;
  logic [CW-1:0]   sel_in, out_sel;
  logic [DW-1:0]   out_data;

  logic [N6*DW-1:0] in_data6;
  logic [N6-1:0]    in_valid6, in_ready6;
  logic             mode_fixed6, out_ready6, out_valid6;
  logic [CW-1:0]    sel_in6, out_sel6;
  logic [DW-1:0]    out_data6;

  logic [CW+DW-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  rr_mux_arb #(.NUM_CH(N), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mode_fixed(mode_fixed), .sel_in(sel_in),
    .out_data(out_data), .out_sel(out_sel), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  rr_mux_arb #(.NUM_CH(N6), .DATA_W(DW)) dut6 (
    .clk(clk), .rst(rst), .in_data(in_data6), .in_valid(in_valid6),
    .in_ready(in_ready6), .mode_fixed(mode_fixed6), .sel_in(sel_in6),
    .out_data(out_data6), .out_sel(out_sel6), .out_valid(out_valid6),
    .out_ready(out_ready6)
  );

  always #5 clk = ~clk;

  function automatic logic [CW+DW-1:0] word(input int ch);
    return {CW'(ch), DW'(160 + ch)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    in_valid    = '0;
    out_ready   = 1'b1;
    mode_fixed  = 1'b0;
    sel_in      = '0;
    in_valid6   = '0;
    out_ready6  = 1'b1;
    mode_fixed6 = 1'b0;
    sel_in6     = '0;
    rst         = 1'b1;
    exp_q.delete();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    in_valid  = '1;
    out_ready = 1'b1;
    #2;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", out_valid);
    else n_pass++;
    n_checks++;
    if (out_data !== 8'h00) $display("FAIL reset_data got=%h exp=00", out_data);
    else n_pass++;
    n_checks++;
    if (out_sel !== 3'd0) $display("FAIL reset_sel got=%0d exp=0", out_sel);
    else n_pass++;
    n_checks++;
    if (in_ready !== 8'h00) $display("FAIL reset_ready got=%b exp=00000000", in_ready);
    else n_pass++;
    tick();
    rst      = 1'b0;
    in_valid = '0;
    #1;
    n_checks++;
    if (in_ready !== 8'h00) $display("FAIL idle_ready got=%b exp=00000000", in_ready);
    else n_pass++;
    tick();
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL idle_valid got=%b exp=0", out_valid);
    else n_pass++;
  endtask

  task automatic test_fixed_scan();
    logic [CW+DW-1:0] w;
    apply_reset();
    mode_fixed = 1'b1;
    in_valid   = '1;
    for (int s = 0; s <= 8; s++) begin
      if (s < 8) sel_in = CW'(s);
      else in_valid = '0;
      #1;
      if (out_valid && out_ready) begin
        n_checks++;
        w = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        if ({out_sel, out_data} !== w) $display("FAIL fixed_out step=%0d got=%h exp=%h", s, {out_sel, out_data}, w);
        else n_pass++;
      end
      if (s < 8) begin
        n_checks++;
        if (in_ready !== 8'(1 << s)) $display("FAIL fixed_ready sel=%0d got=%b exp=%b", s, in_ready, 8'(1 << s));
        else n_pass++;
        exp_q.push_back(word(s));
      end
      tick();
    end
    n_checks++;
    if (out_valid !== 1'b0 || exp_q.size() != 0) $display("FAIL fixed_drain valid=%b left=%0d exp valid=0 left=0", out_valid, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_rr_fair();
    logic [CW+DW-1:0] w;
    apply_reset();
    in_valid = '1;
    for (int i = 0; i <= 10; i++) begin
      if (i == 10) in_valid = '0;
      #1;
      if (i > 0) begin
        n_checks++;
        if (out_valid !== 1'b1) $display("FAIL rr_valid cycle=%0d got=%b exp=1", i, out_valid);
        else n_pass++;
      end
      if (out_valid && out_ready) begin
        n_checks++;
        w = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        if ({out_sel, out_data} !== w) $display("FAIL rr_out cycle=%0d got=%h exp=%h", i, {out_sel, out_data}, w);
        else n_pass++;
      end
      if (i < 10) begin
        n_checks++;
        if (in_ready !== 8'(1 << (i % 8))) $display("FAIL rr_ready cycle=%0d got=%b exp=%b", i, in_ready, 8'(1 << (i % 8)));
        else n_pass++;
        exp_q.push_back(word(i % 8));
      end
      tick();
    end
    n_checks++;
    if (out_valid !== 1'b0 || exp_q.size() != 0) $display("FAIL rr_drain valid=%b left=%0d exp valid=0 left=0", out_valid, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_sparse_wrap();
    logic [CW+DW-1:0] w;
    logic [7:0] pat [7] = '{8'h81, 8'h81, 8'h81, 8'h81, 8'h24, 8'h24, 8'h24};
    int         ch  [7] = '{0, 7, 0, 7, 2, 5, 2};
    apply_reset();
    for (int i = 0; i <= 7; i++) begin
      in_valid = (i < 7) ? pat[i] : 8'h00;
      #1;
      if (out_valid && out_ready) begin
        n_checks++;
        w = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        if ({out_sel, out_data} !== w) $display("FAIL sparse_out step=%0d got=%h exp=%h", i, {out_sel, out_data}, w);
        else n_pass++;
      end
      if (i < 7) begin
        n_checks++;
        if (in_ready !== 8'(1 << ch[i])) $display("FAIL sparse_ready step=%0d got=%b exp=%b", i, in_ready, 8'(1 << ch[i]));
        else n_pass++;
        exp_q.push_back(word(ch[i]));
      end
      tick();
    end
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL sparse_left got=%0d exp=0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [CW+DW-1:0] w;
    logic rdy [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    int   acc [7] = '{0, -1, -1, -1, 1, 2, -1};
    apply_reset();
    in_valid = '1;
    for (int i = 0; i < 7; i++) begin
      out_ready = rdy[i];
      if (i == 6) in_valid = '0;
      #1;
      if (i >= 1 && i <= 3) begin
        n_checks++;
        if (out_valid !== 1'b1 || {out_sel, out_data} !== word(0)) $display("FAIL bp_hold cycle=%0d got=%b/%h exp=1/%h", i, out_valid, {out_sel, out_data}, word(0));
        else n_pass++;
      end
      if (out_valid && out_ready) begin
        n_checks++;
        w = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        if ({out_sel, out_data} !== w) $display("FAIL bp_out cycle=%0d got=%h exp=%h", i, {out_sel, out_data}, w);
        else n_pass++;
      end
      n_checks++;
      if (in_ready !== ((acc[i] >= 0) ? 8'(1 << acc[i]) : 8'h00)) $display("FAIL bp_ready cycle=%0d got=%b exp_ch=%0d", i, in_ready, acc[i]);
      else n_pass++;
      if (acc[i] >= 0) exp_q.push_back(word(acc[i]));
      tick();
    end
    n_checks++;
    if (out_valid !== 1'b0 || exp_q.size() != 0) $display("FAIL bp_drain valid=%b left=%0d exp valid=0 left=0", out_valid, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_invalid_sel();
    apply_reset();
    mode_fixed6 = 1'b1;
    in_valid6   = '1;
    for (int s = 6; s <= 7; s++) begin
      sel_in6 = CW'(s);
      #1;
      n_checks++;
      if (in_ready6 !== 6'h00) $display("FAIL bad_sel_ready sel=%0d got=%b exp=000000", s, in_ready6);
      else n_pass++;
      tick();
      n_checks++;
      if (out_valid6 !== 1'b0) $display("FAIL bad_sel_valid sel=%0d got=%b exp=0", s, out_valid6);
      else n_pass++;
    end
    sel_in6 = 3'd5;
    #1;
    n_checks++;
    if (in_ready6 !== 6'b100000) $display("FAIL sel5_ready got=%b exp=100000", in_ready6);
    else n_pass++;
    tick();
    n_checks++;
    if ({out_valid6, out_sel6, out_data6} !== {1'b1, word(5)}) $display("FAIL sel5_out got=%h exp=%h", {out_valid6, out_sel6, out_data6}, {1'b1, word(5)});
    else n_pass++;
    mode_fixed6 = 1'b0;
    for (int j = 0; j < 7; j++) begin
      #1;
      n_checks++;
      if (in_ready6 !== 6'(1 << (j % 6))) $display("FAIL rr6_ready step=%0d got=%b exp=%b", j, in_ready6, 6'(1 << (j % 6)));
      else n_pass++;
      tick();
      n_checks++;
      if ({out_sel6, out_data6} !== word(j % 6)) $display("FAIL rr6_out step=%0d got=%h exp=%h", j, {out_sel6, out_data6}, word(j % 6));
      else n_pass++;
    end
    in_valid6 = '0;
    tick();
  endtask

  task automatic test_async_reset();
    apply_reset();
    mode_fixed = 1'b1;
    sel_in     = 3'd3;
    in_valid   = '1;
    #1;
    tick();
    in_valid  = '0;
    out_ready = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, out_sel, out_data} !== {1'b1, word(3)}) $display("FAIL ar_full got=%h exp=%h", {out_valid, out_sel, out_data}, {1'b1, word(3)});
    else n_pass++;
    tick();
    #2;
    rst        = 1'b1;
    in_valid   = '1;
    mode_fixed = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, out_sel, out_data} !== 12'h000) $display("FAIL ar_clear got=%h exp=000", {out_valid, out_sel, out_data});
    else n_pass++;
    n_checks++;
    if (in_ready !== 8'h00) $display("FAIL ar_ready_in_rst got=%b exp=00000000", in_ready);
    else n_pass++;
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 8'h01) $display("FAIL ar_first_ready got=%b exp=00000001", in_ready);
    else n_pass++;
    tick();
    n_checks++;
    if ({out_valid, out_sel, out_data} !== {1'b1, word(0)}) $display("FAIL ar_first_out got=%h exp=%h", {out_valid, out_sel, out_data}, {1'b1, word(0)});
    else n_pass++;
    in_valid = '0;
    tick();
  endtask

  initial begin
    for (int i = 0; i < N; i++) in_data[i*DW +: DW] = DW'(160 + i);
    for (int i = 0; i < N6; i++) in_data6[i*DW +: DW] = DW'(160 + i);
    in_valid    = '0;
    mode_fixed  = 1'b0;
    sel_in      = '0;
    out_ready   = 1'b1;
    in_valid6   = '0;
    mode_fixed6 = 1'b0;
    sel_in6     = '0;
    out_ready6  = 1'b1;
    test_reset();
    test_fixed_scan();
    test_rr_fair();
    test_sparse_wrap();
    test_backpressure();
    test_invalid_sel();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
